// File: rtl/branch_flag_unit.sv
// ============================================================================
// Module   : branch_flag_unit
// Purpose  : EX-stage branch flag producer. Compares rs1/rs2 for B-type
//            instructions, registers Z/N and the {funct3, opcode} code for
//            the branch condition handler, holds the branch target, and turns
//            the handler's taken decision into a one-cycle PC redirect plus a
//            multi-cycle IF/ID and ID/EX flush sequence.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_flag_unit #(
   parameter int XLEN         = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_in,
   input  logic            ex_valid,
   input  logic [6:0]      ex_opcode,
   input  logic [2:0]      ex_funct3,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic [XLEN-1:0] pc_ex,
   input  logic [XLEN-1:0] imm_b,
   input  logic            taken_in,
   output logic            Z,
   output logic            N,
   output logic [9:0]      comb_opfunct,
   output logic            flags_valid,
   output logic            redirect,
   output logic [XLEN-1:0] target_pc,
   output logic            flush_ifid,
   output logic            flush_idex,
   output logic            busy
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam logic [6:0] C_OP_BRANCH = 7'b1100011;

   // Counter is wide enough for the full legal FLUSH_CYCLES range (1..15)
   localparam int               CNT_W      = 4;
   localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_FLUSH = 1'b1;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [0:0]      state_q,    state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic            z_q,        z_d;
   logic            n_q,        n_d;
   logic [9:0]      opf_q,      opf_d;
   logic            fv_q,       fv_d;
   logic            redirect_q, redirect_d;
   logic [XLEN-1:0] target_q,   target_d;
   logic [XLEN-1:0] tgt_hold_q, tgt_hold_d;

   // ------------------------------------------------------------------------
   // EX-stage decode and compare
   // ------------------------------------------------------------------------
   logic            w_f3_legal;
   logic            w_is_branch;
   logic            w_eq;
   logic            w_lt;
   logic [XLEN-1:0] w_target_sum;

   // Branch detect and flag compute for the instruction currently in EX
   always_comb begin
      // funct3 010/011 are reserved encodings and never produce live flags
      w_f3_legal  = (ex_funct3 != 3'b010) && (ex_funct3 != 3'b011);
      w_is_branch = ex_valid && (ex_opcode == C_OP_BRANCH) && w_f3_legal;
      w_eq        = (rs1_val == rs2_val);
      // BLTU/BGEU use an unsigned compare; every other branch compares signed
      if (ex_funct3[2:1] == 2'b11) begin
         w_lt = (rs1_val < rs2_val);
      end else begin
         w_lt = ($signed(rs1_val) < $signed(rs2_val));
      end
      // Carry out of the target add is discarded, so the target wraps
      w_target_sum = pc_ex + imm_b;
   end

   // ------------------------------------------------------------------------
   // State register (asynchronous reset; stall handled in next-state logic)
   // ------------------------------------------------------------------------
   // Register all state; reset clears everything immediately, even mid-flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         z_q        <= 1'b0;
         n_q        <= 1'b0;
         opf_q      <= '0;
         fv_q       <= 1'b0;
         redirect_q <= 1'b0;
         target_q   <= '0;
         tgt_hold_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         z_q        <= z_d;
         n_q        <= n_d;
         opf_q      <= opf_d;
         fv_q       <= fv_d;
         redirect_q <= redirect_d;
         target_q   <= target_d;
         tgt_hold_q <= tgt_hold_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   // Compute FSM transition, flag capture and redirect; stall holds everything
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      z_d        = z_q;
      n_d        = n_q;
      opf_d      = opf_q;
      fv_d       = fv_q;
      redirect_d = redirect_q;
      target_d   = target_q;
      tgt_hold_d = tgt_hold_q;

      if (!stall_in) begin
         case (state_q)
            S_IDLE: begin
               if (fv_q && taken_in) begin
                  // Taken: launch redirect, start flush, and squash whatever
                  // instruction sits in EX on this edge
                  state_d    = S_FLUSH;
                  redirect_d = 1'b1;
                  target_d   = tgt_hold_q;
                  cnt_d      = C_CNT_LOAD;
                  z_d        = 1'b0;
                  n_d        = 1'b0;
                  opf_d      = '0;
                  fv_d       = 1'b0;
               end else if (w_is_branch) begin
                  // Capture a new branch (also covers back-to-back not-taken)
                  redirect_d = 1'b0;
                  z_d        = w_eq;
                  n_d        = w_lt;
                  opf_d      = {ex_funct3, ex_opcode};
                  fv_d       = 1'b1;
                  tgt_hold_d = w_target_sum;
               end else begin
                  // Zeroed flags steer the handler to its not-taken default
                  redirect_d = 1'b0;
                  z_d        = 1'b0;
                  n_d        = 1'b0;
                  opf_d      = '0;
                  fv_d       = 1'b0;
               end
            end

            S_FLUSH: begin
               // EX contents are being squashed, so no capture happens here
               redirect_d = 1'b0;
               z_d        = 1'b0;
               n_d        = 1'b0;
               opf_d      = '0;
               fv_d       = 1'b0;
               if (cnt_q == '0) begin
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end

            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Output logic
   // ------------------------------------------------------------------------
   // Drive outputs from registered state; flush lines follow the FLUSH state
   always_comb begin
      Z            = z_q;
      N            = n_q;
      comb_opfunct = opf_q;
      flags_valid  = fv_q;
      redirect     = redirect_q;
      target_pc    = target_q;
      busy         = (state_q == S_FLUSH);
      flush_ifid   = (state_q == S_FLUSH);
      flush_idex   = (state_q == S_FLUSH);
   end

endmodule

`default_nettype wire
